demux_1to8_deser: RTL and testbench

Serial-to-parallel demultiplexer: the receive end of the time-multiplexed link driven by the 8-to-1 mux datapath. Each qualified serial bit is steered into slot `sel` of an 8-bit word, with `sel` advancing 0→7. The completed word is presented on a valid/ready output register. Sits between the serial link and the downstream parallel consumer, and flags words lost to backpressure.

---
 rtl/demux_1to8_deser_if.sv | 26 ++
 rtl/demux_1to8_deser.sv | 108 ++++++++++
 tb/tb_demux_1to8_deser.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/demux_1to8_deser_if.sv
// Serial-link / parallel-word bundle between the bit source, the deserializer and the word consumer.
// master = link driver and word consumer side; slave = deserializer side.
interface demux_1to8_deser_if #(
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
);
   logic             bit_in;
   logic             bit_valid;
   logic             frame_start;
   logic [SEL_W-1:0] sel;
   logic [N-1:0]     data_out;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;
   logic             clear_overrun;

   modport master (
      output bit_in, bit_valid, frame_start, out_ready, clear_overrun,
      input  sel, data_out, out_valid, overrun
   );

   modport slave (
      input  bit_in, bit_valid, frame_start, out_ready, clear_overrun,
      output sel, data_out, out_valid, overrun
   );
endinterface

// File: rtl/demux_1to8_deser.sv
// Serial-to-parallel deserializer; word appears the cycle after its N-th bit, held in a valid/ready register.
// Backpressure: one word buffered plus one assembling; a word completing while the previous is unconsumed is dropped and flagged.
module demux_1to8_deser #(
   parameter int N     = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux_1to8_deser_if.slave    bus
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ostate_t;

   ostate_t          state_q, state_d;
   logic [N-1:0]     acc_q, acc_d;
   logic [N-1:0]     dout_q, dout_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             ovr_q, ovr_d;

   logic [SEL_W-1:0] idx;
   logic [N-1:0]     word;
   logic             done;
   logic             load;
   logic             drop;

   // frame_start realigns: a valid bit on that cycle always lands in slot 0
   always_comb begin
      idx   = bus.frame_start ? '0 : sel_q;
      done  = bus.bit_valid && (idx == SEL_W'(N-1));
      word  = acc_q;
      word[N-1] = bus.bit_in;
      acc_d = acc_q;
      sel_d = sel_q;
      if (bus.bit_valid) begin
         if (done) begin
            acc_d = '0;
            sel_d = '0;
         end else begin
            acc_d[idx] = bus.bit_in;
            sel_d      = idx + 1'b1;
         end
      end else if (bus.frame_start) begin
         acc_d = '0;
         sel_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      load    = 1'b0;
      drop    = 1'b0;
      case (state_q)
         EMPTY: begin
            if (done) begin
               state_d = FULL;
               load    = 1'b1;
            end
         end
         FULL: begin
            if (done && bus.out_ready) begin
               load = 1'b1;
            end else if (done) begin
               drop = 1'b1;
            end else if (bus.out_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (load) begin
         dout_d = word;
      end
      // a drop in the same cycle as a clear keeps the flag set
      if (drop) begin
         ovr_d = 1'b1;
      end else if (bus.clear_overrun) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         acc_q   <= '0;
         dout_q  <= '0;
         sel_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         dout_q  <= dout_d;
         sel_q   <= sel_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.sel       = sel_q;
   assign bus.data_out  = dout_q;
   assign bus.out_valid = (state_q == FULL);
   assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_demux_1to8_deser.sv
// Directed bench for demux_1to8_deser: hand-computed words, backpressure, realignment and reset cases.
module tb_demux_1to8_deser;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   nwords;
   logic [7:0] last_word;

   demux_1to8_deser_if #(.N(8)) bus ();

   demux_1to8_deser #(.N(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // drive one cycle of link inputs, then sample just after the edge
   task automatic cyc(input logic v, input logic b, input logic fs);
      bus.bit_valid   = v;
      bus.bit_in      = b;
      bus.frame_start = fs;
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
         nwords++;
         last_word = bus.data_out;
      end
   endtask

   task automatic send_word(input logic [7:0] w, input logic fs);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, w[i], fs && (i == 0));
      end
   endtask

   initial begin
      logic [7:0] w;
      total = 0;
      bad   = 0;
      nwords = 0;
      last_word = '0;
      rst_n = 1'b0;
      bus.bit_in = 1'b0;
      bus.bit_valid = 1'b0;
      bus.frame_start = 1'b0;
      bus.out_ready = 1'b0;
      bus.clear_overrun = 1'b0;

      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         bus.out_ready     = 1'($urandom);
         bus.clear_overrun = 1'($urandom);
         cyc(1'($urandom), 1'($urandom), 1'($urandom));
      end
      chk("rst_sel", 32'(bus.sel), 32'd0);
      chk("rst_data", 32'(bus.data_out), 32'h00);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_ovr", 32'(bus.overrun), 32'd0);
      rst_n = 1'b1;
      bus.clear_overrun = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // contiguous 0xA5
      bus.out_ready = 1'b1;
      w = 8'hA5;
      nwords = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, w[i], i == 0);
         chk($sformatf("contig_sel%0d", i), 32'(bus.sel), 32'((i + 1) % 8));
      end
      chk("contig_valid", 32'(bus.out_valid), 32'd1);
      chk("contig_data", 32'(bus.data_out), 32'hA5);
      cyc(1'b0, 1'b0, 1'b0);
      chk("contig_valid_1cyc", 32'(bus.out_valid), 32'd0);
      chk("contig_words", 32'(nwords), 32'd1);

      // gap of 3 idle cycles between slots 3 and 4
      for (int i = 0; i < 4; i++) cyc(1'b1, w[i], i == 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         chk("gap_sel_hold", 32'(bus.sel), 32'd4);
      end
      for (int i = 4; i < 8; i++) cyc(1'b1, w[i], 1'b0);
      chk("gap_valid", 32'(bus.out_valid), 32'd1);
      chk("gap_data", 32'(bus.data_out), 32'hA5);
      cyc(1'b0, 1'b0, 1'b0);

      // realignment: three stray ones, then framed 0x3C
      nwords = 0;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
      chk("realign_sel_pre", 32'(bus.sel), 32'd3);
      send_word(8'h3C, 1'b1);
      chk("realign_data", 32'(bus.data_out), 32'h3C);
      cyc(1'b0, 1'b0, 1'b0);
      chk("realign_words", 32'(nwords), 32'd1);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("fs_alone_sel", 32'(bus.sel), 32'd0);
      chk("fs_alone_valid", 32'(bus.out_valid), 32'd0);

      // backpressure with a dropped word
      bus.out_ready = 1'b0;
      send_word(8'h11, 1'b1);
      chk("bp_first_data", 32'(bus.data_out), 32'h11);
      chk("bp_first_ovr", 32'(bus.overrun), 32'd0);
      send_word(8'h22, 1'b1);
      chk("drop_data", 32'(bus.data_out), 32'h11);
      chk("drop_valid", 32'(bus.out_valid), 32'd1);
      chk("drop_ovr", 32'(bus.overrun), 32'd1);
      bus.clear_overrun = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      bus.clear_overrun = 1'b0;
      chk("clear_ovr", 32'(bus.overrun), 32'd0);
      chk("clear_valid", 32'(bus.out_valid), 32'd1);
      w = 8'h44;
      for (int i = 0; i < 7; i++) cyc(1'b1, w[i], i == 0);
      bus.clear_overrun = 1'b1;
      cyc(1'b1, w[7], 1'b0);
      bus.clear_overrun = 1'b0;
      chk("set_wins_ovr", 32'(bus.overrun), 32'd1);
      chk("set_wins_data", 32'(bus.data_out), 32'h11);
      bus.clear_overrun = 1'b1;
      bus.out_ready = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      bus.clear_overrun = 1'b0;
      chk("pop_valid", 32'(bus.out_valid), 32'd0);
      chk("pop_data_kept", 32'(bus.data_out), 32'h11);
      chk("pop_ovr", 32'(bus.overrun), 32'd0);

      // backpressure relieved exactly on the completing cycle
      bus.out_ready = 1'b0;
      send_word(8'h11, 1'b1);
      w = 8'h22;
      for (int i = 0; i < 7; i++) cyc(1'b1, w[i], i == 0);
      bus.out_ready = 1'b1;
      cyc(1'b1, w[7], 1'b0);
      bus.out_ready = 1'b0;
      chk("nodrop_data", 32'(bus.data_out), 32'h22);
      chk("nodrop_valid", 32'(bus.out_valid), 32'd1);
      chk("nodrop_ovr", 32'(bus.overrun), 32'd0);

      // asynchronous reset mid-word, then a clean 0x5A
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 0);
      chk("mid_sel", 32'(bus.sel), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_sel", 32'(bus.sel), 32'd0);
      chk("async_data", 32'(bus.data_out), 32'h00);
      chk("async_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      nwords = 0;
      send_word(8'h5A, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("post_rst_words", 32'(nwords), 32'd1);
      chk("post_rst_data", 32'(last_word), 32'h5A);
      chk("post_rst_ovr", 32'(bus.overrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
